// File: rtl/haar_pkg.sv
// Shared types and default geometry for the Haar front end: scan FSM states,
// pixel width, default window/frame sizes and the fill-count helper.
package haar_pkg;

  typedef enum logic [1:0] {IDLE, FILL, SCAN, DONE} state_t;

  localparam int DATA_WIDTH_12       = 12;
  localparam int DEF_INTEGRAL_WIDTH  = 3;
  localparam int DEF_INTEGRAL_HEIGHT = 3;
  localparam int DEF_FRAME_WIDTH     = 10;
  localparam int DEF_FRAME_HEIGHT    = 10;
  localparam int DEF_COORD_WIDTH     = 12;

  // Pixels the line buffer must absorb before its first complete window.
  function automatic int fill_count(input int frame_width, input int integral_width,
                                    input int integral_height);
    return frame_width * (integral_height - 1) + integral_width;
  endfunction

endpackage

// File: rtl/i2lbs_scan_controller_raster_counter.sv
// Raster column/row counter: advances on enable, wraps at the frame edge and
// flags the last column and the last pixel of the frame.
module raster_counter #(
  parameter int COLS = 10,
  parameter int ROWS = 10,
  parameter int CW   = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          last_col,
  output logic          last_pixel
);

  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [CW-1:0] ROW_MAX = CW'(ROWS - 1);

  assign last_col   = (col == COL_MAX);
  assign last_pixel = last_col && (row == ROW_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (last_col) begin
        col <= '0;
        row <= last_pixel ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2lbs_scan_controller.sv
// Frame sequencer for the integral-image line buffer: pixel handshake, memory
// write strobe, raster tracking and the two-stage window strobe pipeline.
module i2lbs_scan_controller #(
  parameter int DATA_WIDTH_12       = haar_pkg::DATA_WIDTH_12,
  parameter int INTEGRAL_WIDTH      = haar_pkg::DEF_INTEGRAL_WIDTH,
  parameter int INTEGRAL_HEIGHT     = haar_pkg::DEF_INTEGRAL_HEIGHT,
  parameter int FRAME_CAMERA_WIDTH  = haar_pkg::DEF_FRAME_WIDTH,
  parameter int FRAME_CAMERA_HEIGHT = haar_pkg::DEF_FRAME_HEIGHT,
  parameter int COORD_WIDTH         = haar_pkg::DEF_COORD_WIDTH
) (
  input  logic                     clk_os,
  input  logic                     reset_os,
  input  logic                     i_frame_start,
  input  logic [DATA_WIDTH_12-1:0] i_pixel,
  input  logic                     i_pixel_valid,
  output logic                     o_pixel_ready,
  input  logic                     i_classifier_ready,
  output logic                     o_mem_wen,
  output logic [DATA_WIDTH_12-1:0] o_mem_pixel,
  output logic                     o_mem_flush,
  output logic                     o_window_valid,
  output logic [COORD_WIDTH-1:0]   o_window_x,
  output logic [COORD_WIDTH-1:0]   o_window_y,
  output logic                     o_frame_done,
  output logic                     o_busy,
  output haar_pkg::state_t         o_state
);
  import haar_pkg::*;

  if ((longint'(FRAME_CAMERA_WIDTH) >= (longint'(1) << COORD_WIDTH)) ||
      (longint'(FRAME_CAMERA_HEIGHT) >= (longint'(1) << COORD_WIDTH))) begin : g_bad_coord
    $error("frame dimensions do not fit in COORD_WIDTH");
  end
  if ((INTEGRAL_WIDTH > FRAME_CAMERA_WIDTH) || (INTEGRAL_HEIGHT > FRAME_CAMERA_HEIGHT)) begin : g_bad_win
    $error("window larger than frame");
  end

  localparam logic [COORD_WIDTH-1:0] WIN_COL_MIN   = COORD_WIDTH'(INTEGRAL_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] WIN_ROW_MIN   = COORD_WIDTH'(INTEGRAL_HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0] FILL_LAST_COL = COORD_WIDTH'(INTEGRAL_WIDTH - 2);

  state_t                 state_q, state_d;
  logic [COORD_WIDTH-1:0] col, row;
  logic                   last_col, last_pixel;
  logic                   accept, win_hit;
  logic                   win_p1;
  logic [COORD_WIDTH-1:0] win_x_p1, win_y_p1;

  raster_counter #(
    .COLS (FRAME_CAMERA_WIDTH),
    .ROWS (FRAME_CAMERA_HEIGHT),
    .CW   (COORD_WIDTH)
  ) u_raster (
    .clk        (clk_os),
    .rst        (reset_os),
    .clear      (i_frame_start),
    .en         (accept),
    .col        (col),
    .row        (row),
    .last_col   (last_col),
    .last_pixel (last_pixel)
  );

  // Handshake: a pixel transfers on a cycle where i_pixel_valid and
  // o_pixel_ready are both high; ready never depends on valid.
  assign accept  = i_pixel_valid && o_pixel_ready;
  assign win_hit = accept && (col >= WIN_COL_MIN) && (row >= WIN_ROW_MIN);

  always_comb begin
    state_d       = state_q;
    o_pixel_ready = 1'b0;
    unique case (state_q)
      FILL: begin
        o_pixel_ready = 1'b1;
        if (accept && last_pixel) state_d = DONE;
        else if (accept && row == WIN_ROW_MIN && col == FILL_LAST_COL) state_d = SCAN;
      end
      SCAN: begin
        o_pixel_ready = i_classifier_ready;
        if (accept && last_pixel) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase
    // A new frame overrides everything, including a half-scanned one.
    if (i_frame_start) begin
      o_pixel_ready = 1'b0;
      state_d       = FILL;
    end
  end

  always_ff @(posedge clk_os or posedge reset_os) begin
    if (reset_os) begin
      state_q        <= IDLE;
      o_mem_wen      <= 1'b0;
      o_mem_pixel    <= '0;
      o_mem_flush    <= 1'b0;
      win_p1         <= 1'b0;
      win_x_p1       <= '0;
      win_y_p1       <= '0;
      o_window_valid <= 1'b0;
      o_window_x     <= '0;
      o_window_y     <= '0;
    end else begin
      state_q     <= state_d;
      o_mem_flush <= i_frame_start;
      o_mem_wen   <= accept;
      if (accept) o_mem_pixel <= i_pixel;
      win_p1 <= win_hit && !i_frame_start;
      if (win_hit) begin
        win_x_p1 <= col - WIN_COL_MIN;
        win_y_p1 <= row - WIN_ROW_MIN;
      end
      // Second stage lines the strobe up with the memory's post-write outputs.
      o_window_valid <= win_p1 && !i_frame_start;
      if (win_p1 && !i_frame_start) begin
        o_window_x <= win_x_p1;
        o_window_y <= win_y_p1;
      end
    end
  end

  assign o_frame_done = (state_q == DONE);
  assign o_busy       = (state_q == FILL) || (state_q == SCAN);
  assign o_state      = state_q;

endmodule

// File: tb/tb_i2lbs_scan_controller.sv
// Scoreboard bench for i2lbs_scan_controller: driver pushes cycle-tagged
// memory writes and windows, a negedge monitor pops and compares them.
module tb_i2lbs_scan_controller;
  import haar_pkg::*;

  localparam int W_WR  = 44;
  localparam int W_WIN = 56;

  logic        clk_os = 1'b0;
  logic        reset_os = 1'b1;
  logic        i_frame_start = 1'b0;
  logic [11:0] i_pixel = '0;
  logic        i_pixel_valid = 1'b0;
  logic        o_pixel_ready;
  logic        i_classifier_ready = 1'b0;
  logic        o_mem_wen;
  logic [11:0] o_mem_pixel;
  logic        o_mem_flush;
  logic        o_window_valid;
  logic [11:0] o_window_x, o_window_y;
  logic        o_frame_done;
  logic        o_busy;
  state_t      o_state;

  i2lbs_scan_controller dut (
    .clk_os             (clk_os),
    .reset_os           (reset_os),
    .i_frame_start      (i_frame_start),
    .i_pixel            (i_pixel),
    .i_pixel_valid      (i_pixel_valid),
    .o_pixel_ready      (o_pixel_ready),
    .i_classifier_ready (i_classifier_ready),
    .o_mem_wen          (o_mem_wen),
    .o_mem_pixel        (o_mem_pixel),
    .o_mem_flush        (o_mem_flush),
    .o_window_valid     (o_window_valid),
    .o_window_x         (o_window_x),
    .o_window_y         (o_window_y),
    .o_frame_done       (o_frame_done),
    .o_busy             (o_busy),
    .o_state            (o_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk_os = ~clk_os;

  int cyc = 0;
  always @(posedge clk_os) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W_WR-1:0]  wr_q[$];
  logic [W_WIN-1:0] win_q[$];
  int n_checks = 0, n_fail = 0;
  int n_wen = 0, n_win = 0, n_flush = 0, n_done = 0;
  int e_flush = 0, e_done = 0;
  logic [11:0] held_x = '0, held_y = '0;
  state_t mstate = IDLE;
  int mcol = 0, mrow = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_outs"}, {o_pixel_ready, o_mem_wen, o_mem_pixel, o_mem_flush, o_window_valid,
                            o_window_x, o_window_y, o_frame_done, o_busy}, 64'd0);
    check({name, "_state"}, o_state, IDLE);
  endtask

  task automatic model_reset();
    mstate = IDLE;
    mcol = 0;
    mrow = 0;
    held_x = '0;
    held_y = '0;
    wr_q.delete();
    win_q.delete();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_os) begin
    logic [W_WR-1:0]  ew;
    logic [W_WIN-1:0] ev;
    #1;
    if (o_mem_flush) n_flush++;
    if (o_frame_done) n_done++;
    if (o_mem_wen) begin
      n_wen++;
      if (wr_q.size() == 0) check("wen_unexpected", o_mem_wen, 1'b0);
      else begin
        ew = wr_q.pop_front();
        check("mem_write", {32'(cyc), o_mem_pixel}, ew);
      end
    end else if (wr_q.size() > 0 && wr_q[0][43:12] <= 32'(cyc)) begin
      void'(wr_q.pop_front());
      check("wen_missing", o_mem_wen, 1'b1);
    end
    if (o_window_valid) begin
      n_win++;
      if (win_q.size() == 0) check("win_unexpected", o_window_valid, 1'b0);
      else begin
        ev = win_q.pop_front();
        check("window", {32'(cyc), o_window_x, o_window_y}, ev);
        held_x = ev[23:12];
        held_y = ev[11:0];
      end
    end else begin
      if (win_q.size() > 0 && win_q[0][55:24] <= 32'(cyc)) begin
        void'(win_q.pop_front());
        check("win_missing", o_window_valid, 1'b1);
      end
      check("win_hold", {o_window_x, o_window_y}, {held_x, held_y});
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit valid, input logic [11:0] pix, input bit cready,
                       input bit fstart, output bit acc);
    bit exp_ready;
    @(negedge clk_os);
    #2;
    i_pixel_valid      = valid;
    i_pixel            = pix;
    i_classifier_ready = cready;
    i_frame_start      = fstart;
    #1;
    exp_ready = !fstart && (mstate == FILL || (mstate == SCAN && cready));
    check("pixel_ready", o_pixel_ready, exp_ready);
    check("state", o_state, mstate);
    check("busy", o_busy, (mstate == FILL || mstate == SCAN));
    acc = valid && exp_ready;
    if (fstart) begin
      mcol = 0;
      mrow = 0;
      mstate = FILL;
      e_flush++;
      wr_q.delete();
      win_q.delete();
    end else begin
      if (mstate == DONE) begin
        mstate = IDLE;
        e_done++;
      end
      if (acc) begin
        wr_q.push_back({32'(cyc + 1), pix});
        if (mcol >= 2 && mrow >= 2) win_q.push_back({32'(cyc + 2), 12'(mcol - 2), 12'(mrow - 2)});
        if (mcol == 9 && mrow == 9) mstate = DONE;
        else if (mstate == FILL && mrow == 2 && mcol == 1) mstate = SCAN;
        if (mcol == 9) begin
          mcol = 0;
          mrow = mrow + 1;
        end else mcol = mcol + 1;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, 12'd0, 1'b1, 1'b0, acc);
  endtask

  // Frame start, then n_pix accepted pixels (pixel value = index); optional
  // random valid gaps and a 5-cycle classifier stall at pixel stall_at.
  task automatic run_frame(input int n_pix, input bit gaps, input int stall_at);
    bit acc, v, cr;
    int idx, stall_left;
    drive(1'b0, 12'd0, 1'b1, 1'b1, acc);
    idx = 0;
    stall_left = 5;
    while (idx < n_pix) begin
      v  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      cr = 1'b1;
      if (idx == stall_at && stall_left > 0) begin
        cr = 1'b0;
        stall_left--;
      end
      drive(v, 12'(idx), cr, 1'b0, acc);
      if (acc) idx++;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int snap_win, snap_wen, snap_done, snap_flush;

    repeat (3) @(negedge clk_os);
    #1;
    check_reset_outputs("reset");
    #1 reset_os = 1'b0;

    idle_cycles(3);  // valid offered in IDLE: ready must stay low
    begin
      bit acc;
      for (int i = 0; i < 3; i++) drive(1'b1, 12'(i), 1'b1, 1'b0, acc);
    end

    // Continuous full frame
    snap_win = n_win; snap_wen = n_wen; snap_done = n_done; snap_flush = n_flush;
    run_frame(100, 1'b0, -1);
    idle_cycles(4);
    check("frameA_windows", n_win - snap_win, 64);
    check("frameA_writes", n_wen - snap_wen, 100);
    check("frameA_done", n_done - snap_done, 1);
    check("frameA_flush", n_flush - snap_flush, 1);

    // Classifier stall mid-scan
    snap_win = n_win; snap_wen = n_wen;
    run_frame(100, 1'b0, 45);
    idle_cycles(4);
    check("stall_windows", n_win - snap_win, 64);
    check("stall_writes", n_wen - snap_wen, 100);

    // Abort after 50 pixels, then a full frame
    snap_win = n_win; snap_done = n_done; snap_flush = n_flush;
    run_frame(50, 1'b0, -1);
    run_frame(100, 1'b0, -1);
    idle_cycles(4);
    check("abort_windows", n_win - snap_win, 23 + 64);
    check("abort_done", n_done - snap_done, 1);
    check("abort_flush", n_flush - snap_flush, 2);

    // Random valid gaps
    snap_win = n_win; snap_wen = n_wen;
    run_frame(100, 1'b1, -1);
    idle_cycles(4);
    check("gaps_windows", n_win - snap_win, 64);
    check("gaps_writes", n_wen - snap_wen, 100);

    // Asynchronous reset mid-frame
    run_frame(30, 1'b0, -1);
    @(negedge clk_os);
    #2;
    reset_os = 1'b1;
    i_pixel_valid = 1'b0;
    i_frame_start = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    repeat (2) @(negedge clk_os);
    #2 reset_os = 1'b0;
    begin
      bit acc;
      snap_wen = n_wen;
      for (int i = 0; i < 4; i++) drive(1'b1, 12'(i), 1'b1, 1'b0, acc);
      idle_cycles(2);
      check("idle_no_writes", n_wen - snap_wen, 0);
    end

    check("wr_q_empty", wr_q.size(), 0);
    check("win_q_empty", win_q.size(), 0);
    check("flush_total", n_flush, e_flush);
    check("done_total", n_done, e_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2lbs_scan_controller.md
Name: i2lbs_scan_controller

Overview:
Sequences the integral-image line-buffer memory (`I2LBS` row/FIFO datapath) for one camera frame.
- Accepts the camera pixel stream through a valid/ready handshake and drives the memory's write strobe and pixel input.
- Tracks the raster column and row, and flags each cycle in which the memory holds a complete INTEGRAL_WIDTH x INTEGRAL_HEIGHT window.
- Stalls the stream when the downstream Haar classifier is busy, so no window is lost.
- Sits between the camera interface and the memory; its window strobe and coordinates feed the classifier.

Parameters:
- DATA_WIDTH_12, 12, pixel/data width.
- INTEGRAL_WIDTH, 3, window width in pixels.
- INTEGRAL_HEIGHT, 3, window height in pixels.
- FRAME_CAMERA_WIDTH, 10, frame columns.
- FRAME_CAMERA_HEIGHT, 10, frame rows.
- COORD_WIDTH, 12, width of the column/row counters and coordinate outputs.

Ports:
- clk_os  in  1  system clock.
- reset_os  in  1  asynchronous, active-high reset.
- i_frame_start  in  1  one-cycle pulse: a new frame begins.
- i_pixel  in  DATA_WIDTH_12  camera pixel.
- i_pixel_valid  in  1  i_pixel is valid.
- o_pixel_ready  out  1  controller accepts the pixel this cycle.
- i_classifier_ready  in  1  classifier can take a window.
- o_mem_wen  out  1  write strobe to the line-buffer memory.
- o_mem_pixel  out  DATA_WIDTH_12  pixel to the memory.
- o_mem_flush  out  1  one-cycle pulse: clear memory contents for a new frame.
- o_window_valid  out  1  memory outputs hold a complete window.
- o_window_x  out  COORD_WIDTH  window top-left column.
- o_window_y  out  COORD_WIDTH  window top-left row.
- o_frame_done  out  1  one-cycle pulse after the last pixel of the frame.
- o_busy  out  1  state is FILL or SCAN.

Behaviour:
- Reset: the clock is clk_os; reset_os is asynchronous and active-high. While reset is asserted:
  - state = IDLE;
  - all outputs = 0;
  - col = 0, row = 0.
- States are IDLE, FILL, SCAN and DONE.
  - IDLE: o_pixel_ready = 0; pixels are ignored.
  - i_frame_start (in any state, including mid-frame) takes priority:
    - col and row clear to 0;
    - o_mem_flush pulses for one cycle;
    - next state = FILL;
    - o_pixel_ready = 0 in the cycle i_frame_start is high.
  - FILL: o_pixel_ready = 1, independent of i_classifier_ready.
    - Move to SCAN on the accept where row = INTEGRAL_HEIGHT-1 and col = INTEGRAL_WIDTH-2.
    - That accept is pixel number FRAME_CAMERA_WIDTH*(INTEGRAL_HEIGHT-1)+INTEGRAL_WIDTH-1, counting from 1.
  - SCAN: o_pixel_ready = i_classifier_ready.
  - Last pixel (col = FRAME_CAMERA_WIDTH-1, row = FRAME_CAMERA_HEIGHT-1) accepted → go to DONE.
  - DONE: o_frame_done = 1 for one cycle, then go to IDLE.
- Accept = i_pixel_valid & o_pixel_ready.
  - On the accepting edge, o_mem_wen <= 1 and o_mem_pixel <= i_pixel.
  - Otherwise o_mem_wen <= 0 and o_mem_pixel holds its value.
  - The memory therefore writes one cycle after the accept.
- Counters:
  - col increments on each accept.
  - At FRAME_CAMERA_WIDTH-1, col wraps to 0 and row increments.
  - Counters do not advance without an accept.
- Window strobe:
  - An accepted pixel at (col, row) with col >= INTEGRAL_WIDTH-1 and row >= INTEGRAL_HEIGHT-1 completes a window.
  - o_window_valid pulses for exactly 1 cycle, 2 edges after the accept, aligned with the memory's updated outputs.
  - Coordinates are x = col-(INTEGRAL_WIDTH-1) and y = row-(INTEGRAL_HEIGHT-1), registered with the strobe and held until the next strobe.
- Backpressure: i_classifier_ready low in SCAN means no accepts, no writes, and frozen memory contents; o_window_valid stays 0.
  - A window already in flight is still strobed, because the classifier samples readiness at accept time.
- Boundaries:
  - Column wrap produces no window for col < INTEGRAL_WIDTH-1.
  - i_frame_start mid-frame discards the partial frame without asserting o_frame_done; any in-flight o_mem_wen/o_window_valid is squashed.
  - reset_os mid-frame returns to IDLE immediately.
- Counter comparisons use COORD_WIDTH unsigned arithmetic.
  - Elaboration must check that FRAME_CAMERA_WIDTH and FRAME_CAMERA_HEIGHT are each < 2^COORD_WIDTH.
  - Elaboration must check that INTEGRAL_WIDTH <= FRAME_CAMERA_WIDTH and INTEGRAL_HEIGHT <= FRAME_CAMERA_HEIGHT.

Decomposition:
- Shared package (haar_pkg):
  - state enum: IDLE/FILL/SCAN/DONE;
  - DATA_WIDTH_12;
  - default window and frame dimensions;
  - fill-count function FRAME_CAMERA_WIDTH*(INTEGRAL_HEIGHT-1)+INTEGRAL_WIDTH.
- One natural sub-module, raster_counter: a col/row counter with enable, clear, wrap, and last-column and last-pixel flags.
- FSM, handshake and window pipeline stay in i2lbs_scan_controller.

Test Plan (default 3x3 window, 10x10 frame, i_pixel = sequence index):
- Reset mid-stream → all outputs 0 and state IDLE; pixels offered in IDLE → o_pixel_ready = 0 and no o_mem_wen.
- i_frame_start, then 100 pixels with continuous valid and classifier ready:
  - o_mem_flush pulses once;
  - 100 o_mem_wen pulses;
  - first o_window_valid 2 cycles after pixel 23 (index 22), at (0,0);
  - 64 windows in total, last at (7,7);
  - o_frame_done pulses once.
- Row 2, col 1 (pixel 22) accepted → no window; col 2 → window (0,0); col 0 of row 3 → no window.
- i_classifier_ready low for 5 cycles during SCAN → o_pixel_ready = 0, no writes, coordinates unchanged.
  - On release, the next window continues at the next x with no gap or duplicate.
- i_frame_start after pixel 50 → counters clear, flush pulses, no o_frame_done; a following full frame again yields 64 windows starting at (0,0).
- Random i_pixel_valid gaps → window count and coordinate sequence identical to the continuous case.
